e203_icb_sram_resp: RTL and testbench

- ICB responder that terminates an LSU-side ICB port (DTCM-class traffic) onto a single-port synchronous SRAM with 1-cycle read latency.
- Accepts cmds, issues SRAM accesses, and returns in-order responses through a 2-entry response buffer so rsp back-pressure never drops data.
- Adds address/alignment error detection and a single-reservation exclusive monitor for lock/excl (LR/SC) traffic.

---
 rtl/e203_icb_sram_resp_pkg.sv | 37 +++
 rtl/e203_icb_sram_resp_if.sv | 35 +++
 rtl/e203_icb_rsp_fifo.sv | 56 +++++
 rtl/e203_icb_sram_resp.sv | 144 ++++++++++++++
 tb/tb_e203_icb_sram_resp.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/e203_icb_sram_resp_pkg.sv
// Shared types and helpers for the ICB-to-SRAM responder: size encodings,
// the response record carried through the response buffer, and the
// command legality check.
package e203_icb_sram_resp_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } icb_size_e;

    // Response record: {err, excl_ok, rdata}
    localparam int RSP_W = 34;

    typedef struct packed {
        logic        err;
        logic        excl_ok;
        logic [31:0] rdata;
    } rsp_t;

    // Out-of-range, reserved size, or misaligned half/word access.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input logic [31:0] mem_bytes,
                                      input logic [1:0]  size);
        logic e;
        e = (addr >= mem_bytes);
        case (icb_size_e'(size))
            SZ_HALF: e = e | addr[0];
            SZ_WORD: e = e | (addr[1:0] != 2'b00);
            SZ_RSVD: e = 1'b1;
            default: e = e;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/e203_icb_sram_resp_if.sv
// ICB command/response channel between an LSU-side master and the responder.
interface e203_icb_sram_resp_if #(
    parameter int AW = 16
);
    logic          icb_cmd_valid;
    logic          icb_cmd_ready;
    logic [AW-1:0] icb_cmd_addr;
    logic          icb_cmd_read;
    logic [31:0]   icb_cmd_wdata;
    logic [3:0]    icb_cmd_wmask;
    logic          icb_cmd_lock;
    logic          icb_cmd_excl;
    logic [1:0]    icb_cmd_size;
    logic          icb_rsp_valid;
    logic          icb_rsp_ready;
    logic          icb_rsp_err;
    logic          icb_rsp_excl_ok;
    logic [31:0]   icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
               icb_cmd_wmask, icb_cmd_lock, icb_cmd_excl, icb_cmd_size,
               icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_excl_ok,
               icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
               icb_cmd_wmask, icb_cmd_lock, icb_cmd_excl, icb_cmd_size,
               icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_excl_ok,
               icb_rsp_rdata
    );
endinterface

// File: rtl/e203_icb_rsp_fifo.sv
// Two-entry response buffer; holds responses the master has not yet taken.
module e203_icb_rsp_fifo
    import e203_icb_sram_resp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [RSP_W-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [RSP_W-1:0] out_data_o,
    output logic [1:0]       count_o
);

    logic [RSP_W-1:0] mem_q [2];
    logic             wptr_q, rptr_q;
    logic [1:0]       cnt_q, cnt_d;
    logic             push, pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rptr_q];
    assign count_o     = cnt_q;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // Occupancy follows push/pop; simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push) wptr_q <= ~wptr_q;
            if (pop)  rptr_q <= ~rptr_q;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are meaningless until counted valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= in_data_i;
    end

endmodule

// File: rtl/e203_icb_sram_resp.sv
// ICB responder for a single-port SRAM with 1-cycle read latency. Commands
// are checked and issued in the fire cycle, the response is offered the next
// cycle straight from ram_dout, and anything the master cannot take is parked
// in a 2-entry buffer. Also tracks one LR/SC reservation.
module e203_icb_sram_resp
    import e203_icb_sram_resp_pkg::*;
#(
    parameter int AW        = 16,
    parameter int MEM_BYTES = 65536,
    parameter int RAW       = AW - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 excl_clr,
    e203_icb_sram_resp_if.slave  icb,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic [RAW-1:0]       ram_addr,
    output logic [3:0]           ram_wem,
    output logic [31:0]          ram_din,
    input  logic [31:0]          ram_dout
);

    logic           cmd_fire, cmd_err, wr_permit, cmd_excl_ok;
    logic [RAW-1:0] cmd_word;
    logic           pend_vld_q, pend_err_q, pend_xok_q, pend_rd_q;
    logic           resv_vld_q, resv_vld_d;
    logic [RAW-1:0] resv_addr_q, resv_addr_d;
    rsp_t           pend_rsp, fifo_rsp;
    logic           fifo_push, fifo_vld, unused_fifo_in_rdy;
    logic [1:0]     fifo_cnt, occupancy;
    logic           rsp_fire;
    logic           unused_lock;

    // Lock has no meaning for a single-port SRAM beyond being carried on the bus.
    assign unused_lock = icb.icb_cmd_lock;

    assign cmd_word    = icb.icb_cmd_addr[AW-1:2];
    assign cmd_err     = addr_err(32'(icb.icb_cmd_addr), 32'(MEM_BYTES), icb.icb_cmd_size);
    assign wr_permit   = ~icb.icb_cmd_excl | (resv_vld_q & (resv_addr_q == cmd_word));
    assign cmd_excl_ok = icb.icb_cmd_excl & ~cmd_err & (icb.icb_cmd_read | wr_permit);

    // Pending stage plus buffered entries never exceed two, so a new command
    // is taken only when a slot is free or one is leaving this cycle.
    assign occupancy         = {1'b0, pend_vld_q} + fifo_cnt;
    assign rsp_fire          = icb.icb_rsp_valid & icb.icb_rsp_ready;
    assign icb.icb_cmd_ready = (occupancy < 2'd2) | rsp_fire;
    assign cmd_fire          = icb.icb_cmd_valid & icb.icb_cmd_ready;

    // A failed SC still selects the SRAM but suppresses the write.
    assign ram_cs   = cmd_fire & ~cmd_err;
    assign ram_we   = ram_cs & ~icb.icb_cmd_read & wr_permit;
    assign ram_addr = cmd_word;
    assign ram_wem  = icb.icb_cmd_wmask;
    assign ram_din  = icb.icb_cmd_wdata;

    // Capture the attributes of the fired command for next-cycle response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld_q <= 1'b0;
            pend_err_q <= 1'b0;
            pend_xok_q <= 1'b0;
            pend_rd_q  <= 1'b0;
        end else begin
            pend_vld_q <= cmd_fire;
            if (cmd_fire) begin
                pend_err_q <= cmd_err;
                pend_xok_q <= cmd_excl_ok;
                pend_rd_q  <= icb.icb_cmd_read;
            end
        end
    end

    // Reservation update: LR sets, any SC or a plain write to the word clears,
    // erroring commands leave it alone, and excl_clr overrides everything.
    always_comb begin
        resv_vld_d  = resv_vld_q;
        resv_addr_d = resv_addr_q;
        if (cmd_fire & ~cmd_err) begin
            if (icb.icb_cmd_excl & icb.icb_cmd_read) begin
                resv_vld_d  = 1'b1;
                resv_addr_d = cmd_word;
            end else if (icb.icb_cmd_excl) begin
                resv_vld_d = 1'b0;
            end else if (~icb.icb_cmd_read & (cmd_word == resv_addr_q)) begin
                resv_vld_d = 1'b0;
            end
        end
        if (excl_clr) resv_vld_d = 1'b0;
    end

    // Reservation valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) resv_vld_q <= 1'b0;
        else     resv_vld_q <= resv_vld_d;
    end

    // Reservation address; only meaningful while the flag is set.
    always_ff @(posedge clk) begin
        resv_addr_q <= resv_addr_d;
    end

    // Response from the pending stage, reading SRAM data in its valid cycle.
    always_comb begin
        pend_rsp.err     = pend_err_q;
        pend_rsp.excl_ok = pend_xok_q;
        pend_rsp.rdata   = (pend_rd_q & ~pend_err_q) ? ram_dout : 32'h0;
    end

    // Park the pending response unless it leaves via the bypass this cycle.
    assign fifo_push = pend_vld_q & ~(~fifo_vld & icb.icb_rsp_ready);

    e203_icb_rsp_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (fifo_push),
        .in_ready_o  (unused_fifo_in_rdy),
        .in_data_i   (pend_rsp),
        .out_valid_o (fifo_vld),
        .out_ready_i (icb.icb_rsp_ready),
        .out_data_o  (fifo_rsp),
        .count_o     (fifo_cnt)
    );

    // Oldest response first: buffer head, else the pending-stage bypass.
    always_comb begin
        icb.icb_rsp_valid   = 1'b0;
        icb.icb_rsp_err     = 1'b0;
        icb.icb_rsp_excl_ok = 1'b0;
        icb.icb_rsp_rdata   = 32'h0;
        if (fifo_vld) begin
            icb.icb_rsp_valid   = 1'b1;
            icb.icb_rsp_err     = fifo_rsp.err;
            icb.icb_rsp_excl_ok = fifo_rsp.excl_ok;
            icb.icb_rsp_rdata   = fifo_rsp.rdata;
        end else if (pend_vld_q) begin
            icb.icb_rsp_valid   = 1'b1;
            icb.icb_rsp_err     = pend_rsp.err;
            icb.icb_rsp_excl_ok = pend_rsp.excl_ok;
            icb.icb_rsp_rdata   = pend_rsp.rdata;
        end
    end

endmodule

// File: tb/tb_e203_icb_sram_resp.sv
// Bench for e203_icb_sram_resp: table of commands with hand-derived SRAM-side
// and response expectations, plus sequences for back-pressure, excl_clr and
// reset while responses are buffered.
module tb_e203_icb_sram_resp;

    localparam int AW  = 17;
    localparam int RAW = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            excl_clr = 1'b0;
    logic            ram_cs, ram_we;
    logic [RAW-1:0]  ram_addr;
    logic [3:0]      ram_wem;
    logic [31:0]     ram_din;
    logic [31:0]     ram_dout;

    e203_icb_sram_resp_if #(.AW(AW)) icb ();

    e203_icb_sram_resp #(.AW(AW), .MEM_BYTES(65536), .RAW(RAW)) dut (
        .clk      (clk),
        .rst      (rst),
        .excl_clr (excl_clr),
        .icb      (icb),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wem  (ram_wem),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model with a backdoor loader
    logic [31:0]    sram [32768];
    logic           bd_we = 1'b0;
    logic [RAW-1:0] bd_addr = '0;
    logic [31:0]    bd_data = '0;
    always @(posedge clk) begin
        if (bd_we) sram[bd_addr] <= bd_data;
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= sram[ram_addr];
            end
        end
    end

    typedef struct {
        logic           rd;
        logic [AW-1:0]  addr;
        logic [31:0]    wdata;
        logic [3:0]     wmask;
        logic           excl;
        logic [1:0]     size;
        logic           clr;
        logic           e_cs;
        logic           e_we;
        logic [RAW-1:0] e_addr;
        logic           e_err;
        logic           e_xok;
        logic [31:0]    e_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic        xok;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    vec_t vt[$];
    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    logic lat_chk = 1'b0;

    function automatic vec_t mk(logic rd, logic [AW-1:0] a, logic [31:0] wd, logic [3:0] wm,
                                logic x, logic [1:0] sz, logic clr, logic cs, logic we,
                                logic [RAW-1:0] ra, logic err, logic xok, logic [31:0] rdat);
        vec_t v;
        v.rd = rd; v.addr = a; v.wdata = wd; v.wmask = wm; v.excl = x; v.size = sz; v.clr = clr;
        v.e_cs = cs; v.e_we = we; v.e_addr = ra; v.e_err = err; v.e_xok = xok; v.e_rdata = rdat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic bd_load(input logic [RAW-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic push_exp(input logic err, input logic xok, input logic [31:0] rdata);
        exp_t e;
        e.err = err; e.xok = xok; e.rdata = rdata; e.cyc = cyc;
        sbq.push_back(e);
    endtask

    task automatic issue(input vec_t v);
        int t;
        @(posedge clk); #1;
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_read  = v.rd;
        icb.icb_cmd_addr  = v.addr;
        icb.icb_cmd_wdata = v.wdata;
        icb.icb_cmd_wmask = v.wmask;
        icb.icb_cmd_excl  = v.excl;
        icb.icb_cmd_size  = v.size;
        excl_clr          = v.clr;
        t = 0;
        @(negedge clk);
        while (!icb.icb_cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!icb.icb_cmd_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cmd_timeout: ready=0 after %0d cycles, required 1", t);
        end else begin
            chk("ram_cs", 32'(ram_cs), 32'(v.e_cs));
            chk("ram_we", 32'(ram_we), 32'(v.e_we));
            if (v.e_cs) chk("ram_addr", 32'(ram_addr), 32'(v.e_addr));
            if (v.e_we) begin
                chk("ram_wem", 32'(ram_wem), 32'(v.wmask));
                chk("ram_din", ram_din, v.wdata);
            end
            push_exp(v.e_err, v.e_xok, v.e_rdata);
        end
        @(posedge clk); #1;
        icb.icb_cmd_valid = 1'b0;
        excl_clr          = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
        end
    endtask

    // Response scoreboard and buffer-overflow watch.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && icb.icb_rsp_valid && icb.icb_rsp_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata %08h with no outstanding command", icb.icb_rsp_rdata);
            end else begin
                e = sbq.pop_front();
                chk("rsp_err", 32'(icb.icb_rsp_err), 32'(e.err));
                chk("rsp_excl_ok", 32'(icb.icb_rsp_excl_ok), 32'(e.xok));
                chk("rsp_rdata", icb.icb_rsp_rdata, e.rdata);
                if (lat_chk) chk("rsp_latency", 32'(cyc), 32'(e.cyc + 1));
            end
        end
        if (dut.fifo_push && dut.fifo_cnt == 2'd2) begin
            n_fail++;
            $display("FAIL fifo_overflow: push with count %0d, required below 2", dut.fifo_cnt);
        end
    end

    initial begin
        icb.icb_cmd_valid = 1'b0;
        icb.icb_cmd_read  = 1'b0;
        icb.icb_cmd_addr  = '0;
        icb.icb_cmd_wdata = '0;
        icb.icb_cmd_wmask = '0;
        icb.icb_cmd_lock  = 1'b0;
        icb.icb_cmd_excl  = 1'b0;
        icb.icb_cmd_size  = 2'd2;
        icb.icb_rsp_ready = 1'b1;

        //    rd addr      wdata         wm    x  sz clr cs we ra       err xok rdata
        vt.push_back(mk(0, 17'h00010, 32'hDEADBEEF, 4'hF, 0, 2, 0, 1, 1, 15'h0004, 0, 0, 32'h0));
        vt.push_back(mk(1, 17'h00010, 32'h0,        4'hF, 0, 2, 0, 1, 0, 15'h0004, 0, 0, 32'hDEADBEEF));
        vt.push_back(mk(0, 17'h00012, 32'h00AA0000, 4'h4, 0, 0, 0, 1, 1, 15'h0004, 0, 0, 32'h0));
        vt.push_back(mk(1, 17'h00010, 32'h0,        4'hF, 0, 2, 0, 1, 0, 15'h0004, 0, 0, 32'hDEAABEEF));
        vt.push_back(mk(1, 17'h10000, 32'h0,        4'hF, 0, 2, 0, 0, 0, 15'h0000, 1, 0, 32'h0));
        vt.push_back(mk(1, 17'h00003, 32'h0,        4'hF, 0, 1, 0, 0, 0, 15'h0000, 1, 0, 32'h0));
        vt.push_back(mk(1, 17'h00000, 32'h0,        4'hF, 0, 3, 0, 0, 0, 15'h0000, 1, 0, 32'h0));
        vt.push_back(mk(1, 17'h00002, 32'h0,        4'hF, 0, 2, 0, 0, 0, 15'h0000, 1, 0, 32'h0));
        vt.push_back(mk(0, 17'h00002, 32'h12340000, 4'hC, 0, 1, 0, 1, 1, 15'h0000, 0, 0, 32'h0));
        vt.push_back(mk(1, 17'h00000, 32'h0,        4'hF, 0, 2, 0, 1, 0, 15'h0000, 0, 0, 32'h12340011));
        vt.push_back(mk(1, 17'h00020, 32'h0,        4'hF, 1, 2, 0, 1, 0, 15'h0008, 0, 1, 32'h0));
        vt.push_back(mk(0, 17'h00020, 32'h5,        4'hF, 1, 2, 0, 1, 1, 15'h0008, 0, 1, 32'h0));
        vt.push_back(mk(0, 17'h00020, 32'h6,        4'hF, 1, 2, 0, 1, 0, 15'h0008, 0, 0, 32'h0));
        vt.push_back(mk(1, 17'h00020, 32'h0,        4'hF, 0, 2, 0, 1, 0, 15'h0008, 0, 0, 32'h5));
        vt.push_back(mk(1, 17'h00020, 32'h0,        4'hF, 1, 2, 0, 1, 0, 15'h0008, 0, 1, 32'h5));
        vt.push_back(mk(0, 17'h00020, 32'h7,        4'hF, 0, 2, 0, 1, 1, 15'h0008, 0, 0, 32'h0));
        vt.push_back(mk(0, 17'h00020, 32'h9,        4'hF, 1, 2, 0, 1, 0, 15'h0008, 0, 0, 32'h0));
        vt.push_back(mk(1, 17'h00020, 32'h0,        4'hF, 0, 2, 0, 1, 0, 15'h0008, 0, 0, 32'h7));
        vt.push_back(mk(1, 17'h00024, 32'h0,        4'hF, 1, 2, 0, 1, 0, 15'h0009, 0, 1, 32'h99));
        vt.push_back(mk(1, 17'h00028, 32'h0,        4'hF, 1, 2, 0, 1, 0, 15'h000A, 0, 1, 32'hAA));
        vt.push_back(mk(0, 17'h00024, 32'h1,        4'hF, 1, 2, 0, 1, 0, 15'h0009, 0, 0, 32'h0));
        vt.push_back(mk(0, 17'h00028, 32'h2,        4'hF, 1, 2, 0, 1, 0, 15'h000A, 0, 0, 32'h0));
        vt.push_back(mk(1, 17'h00020, 32'h0,        4'hF, 1, 2, 0, 1, 0, 15'h0008, 0, 1, 32'h7));
        vt.push_back(mk(1, 17'h10000, 32'h0,        4'hF, 1, 2, 0, 0, 0, 15'h0000, 1, 0, 32'h0));
        vt.push_back(mk(0, 17'h00022, 32'h3,        4'hF, 1, 2, 0, 0, 0, 15'h0000, 1, 0, 32'h0));
        vt.push_back(mk(0, 17'h00020, 32'hA,        4'hF, 1, 2, 0, 1, 1, 15'h0008, 0, 1, 32'h0));
        vt.push_back(mk(1, 17'h00020, 32'h0,        4'hF, 0, 2, 0, 1, 0, 15'h0008, 0, 0, 32'hA));
        vt.push_back(mk(1, 17'h00020, 32'h0,        4'hF, 1, 2, 1, 1, 0, 15'h0008, 0, 1, 32'hA));
        vt.push_back(mk(0, 17'h00020, 32'hB,        4'hF, 1, 2, 0, 1, 0, 15'h0008, 0, 0, 32'h0));
        vt.push_back(mk(1, 17'h0FFFC, 32'h0,        4'hF, 0, 2, 0, 1, 0, 15'h3FFF, 0, 0, 32'hCAFEF00D));
        vt.push_back(mk(1, 17'h0FFFF, 32'h0,        4'hF, 0, 0, 0, 1, 0, 15'h3FFF, 0, 0, 32'hCAFEF00D));
        vt.push_back(mk(1, 17'h10003, 32'h0,        4'hF, 0, 0, 0, 0, 0, 15'h0000, 1, 0, 32'h0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(icb.icb_rsp_valid), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(icb.icb_cmd_ready), 32'h1);
        chk("rst_rsp_valid", 32'(icb.icb_rsp_valid), 32'h0);
        chk("rst_rsp_err", 32'(icb.icb_rsp_err), 32'h0);
        chk("rst_rsp_excl_ok", 32'(icb.icb_rsp_excl_ok), 32'h0);
        chk("rst_rsp_rdata", icb.icb_rsp_rdata, 32'h0);

        bd_load(15'h0000, 32'h11);
        bd_load(15'h0001, 32'h22);
        bd_load(15'h0002, 32'h33);
        bd_load(15'h0008, 32'h0);
        bd_load(15'h0009, 32'h99);
        bd_load(15'h000A, 32'hAA);
        bd_load(15'h3FFF, 32'hCAFEF00D);

        // Table of single commands, master always ready
        lat_chk = 1'b1;
        for (int i = 0; i < vt.size(); i++) issue(vt[i]);
        drain();

        // excl_clr pulse between LR and SC
        issue(mk(1, 17'h00020, 32'h0, 4'hF, 1, 2, 0, 1, 0, 15'h0008, 0, 1, 32'hA));
        @(posedge clk); #1;
        excl_clr = 1'b1;
        @(posedge clk); #1;
        excl_clr = 1'b0;
        issue(mk(0, 17'h00020, 32'hC, 4'hF, 1, 2, 0, 1, 0, 15'h0008, 0, 0, 32'h0));
        issue(mk(1, 17'h00020, 32'h0, 4'hF, 0, 2, 0, 1, 0, 15'h0008, 0, 0, 32'hA));
        drain();

        // Back-pressure: two responses buffered, third command must stall
        lat_chk = 1'b0;
        bd_load(15'h0000, 32'h11);
        icb.icb_rsp_ready = 1'b0;
        issue(mk(1, 17'h00000, 32'h0, 4'hF, 0, 2, 0, 1, 0, 15'h0000, 0, 0, 32'h11));
        issue(mk(1, 17'h00004, 32'h0, 4'hF, 0, 2, 0, 1, 0, 15'h0001, 0, 0, 32'h22));
        @(posedge clk); #1;
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_read  = 1'b1;
        icb.icb_cmd_addr  = 17'h00008;
        icb.icb_cmd_excl  = 1'b0;
        icb.icb_cmd_size  = 2'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_cmd_ready", 32'(icb.icb_cmd_ready), 32'h0);
            chk("bp_rsp_valid", 32'(icb.icb_rsp_valid), 32'h1);
            chk("bp_rsp_head", icb.icb_rsp_rdata, 32'h11);
        end
        @(posedge clk); #1;
        icb.icb_rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(icb.icb_cmd_ready), 32'h1);
        if (icb.icb_cmd_ready) push_exp(1'b0, 1'b0, 32'h33);
        @(posedge clk); #1;
        icb.icb_cmd_valid = 1'b0;
        drain();
        @(negedge clk);
        chk("bp_idle_ready", 32'(icb.icb_cmd_ready), 32'h1);

        // Reset with two responses buffered and a reservation held
        issue(mk(1, 17'h00020, 32'h0, 4'hF, 1, 2, 0, 1, 0, 15'h0008, 0, 1, 32'hA));
        drain();
        icb.icb_rsp_ready = 1'b0;
        issue(mk(1, 17'h00000, 32'h0, 4'hF, 0, 2, 0, 1, 0, 15'h0000, 0, 0, 32'h11));
        issue(mk(1, 17'h00004, 32'h0, 4'hF, 0, 2, 0, 1, 0, 15'h0001, 0, 0, 32'h22));
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 32'(icb.icb_rsp_valid), 32'h0);
        sbq.delete();
        @(posedge clk); #3;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(icb.icb_cmd_ready), 32'h1);
        chk("post_rst_rsp_valid", 32'(icb.icb_rsp_valid), 32'h0);
        icb.icb_rsp_ready = 1'b1;
        issue(mk(1, 17'h00004, 32'h0, 4'hF, 0, 2, 0, 1, 0, 15'h0001, 0, 0, 32'h22));
        issue(mk(0, 17'h00020, 32'hD, 4'hF, 1, 2, 0, 1, 0, 15'h0008, 0, 0, 32'h0));
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
